// File: rtl/ofmap_drain.sv
// Streams the GEMM ofmap BRAM out on a valid/ready port, one read per cycle.
// A skid FIFO covers the 1-cycle BRAM latency so that backpressure never drops or repeats a word.
module ofmap_drain #(
  parameter int MEM2_DATA_WIDTH = 112,
  parameter int MEM2_ADDR_WIDTH = 10,
  parameter int MEM2_DEPTH      = 896,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  output logic                       mem2_ce1,
  output logic                       mem2_we1,
  output logic [MEM2_ADDR_WIDTH-1:0] mem2_addr1,
  input  logic [MEM2_DATA_WIDTH-1:0] mem2_q1,
  output logic                       m_valid_o,
  input  logic                       m_ready_i,
  output logic [MEM2_DATA_WIDTH-1:0] m_data_o,
  output logic                       m_last_o,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [MEM2_ADDR_WIDTH-1:0] LAST_ADDR = MEM2_ADDR_WIDTH'(MEM2_DEPTH - 1);
  localparam logic [CW:0]                FD        = (CW + 1)'(FIFO_DEPTH);
  localparam logic [PW-1:0]              PTR_MAX   = PW'(FIFO_DEPTH - 1);

  logic [1:0]                 state_q, state_d;
  logic [MEM2_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CW-1:0]              count_q, count_d;
  logic                       inflight_q, inflight_d;
  logic                       tag_q, tag_d;
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [MEM2_DATA_WIDTH:0]   fifo_mem_q [FIFO_DEPTH];
  logic [MEM2_DATA_WIDTH:0]   fifo_mem_d [FIFO_DEPTH];

  logic [CW:0]              occ;
  logic                     issue, empty, push, pop;
  logic [MEM2_DATA_WIDTH:0] head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_MAX) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    // Issue only when every outstanding word is guaranteed a FIFO slot.
    occ   = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    issue = (state_q == S_RUN) && (occ < FD);
    empty = (count_q == '0);
    push  = inflight_q;
    pop   = !empty && m_ready_i;
    head  = fifo_mem_q[rd_ptr_q];

    state_d    = state_q;
    addr_d     = addr_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_mem_d = fifo_mem_q;
    inflight_d = issue;
    tag_d      = issue && (addr_q == LAST_ADDR);

    if (issue) addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
    if (push) begin
      fifo_mem_d[wr_ptr_q] = {tag_q, mem2_q1};
      wr_ptr_d             = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    case (state_q)
      S_IDLE:  if (start_i) state_d = S_RUN;
      S_RUN:   if (issue && (addr_q == LAST_ADDR)) state_d = S_FLUSH;
      S_FLUSH: if (pop && head[MEM2_DATA_WIDTH]) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      tag_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
    // Storage needs no reset; the cleared pointers and count make it unreachable.
    fifo_mem_q <= fifo_mem_d;
  end

  assign mem2_ce1   = issue;
  assign mem2_we1   = 1'b0;
  assign mem2_addr1 = addr_q;
  assign m_valid_o  = !empty;
  assign m_data_o   = empty ? '0 : head[MEM2_DATA_WIDTH-1:0];
  assign m_last_o   = !empty && head[MEM2_DATA_WIDTH];
  assign busy_o     = (state_q == S_RUN) || (state_q == S_FLUSH);
  assign done_o     = (state_q == S_DONE);

endmodule

// File: tb/tb_ofmap_drain.sv
// Directed bench for ofmap_drain: table of drain scenarios on the default build,
// plus a hand sequence on a MEM2_DEPTH=1 / FIFO_DEPTH=3 build.
module tb_ofmap_drain;

  localparam int DW = 112;
  localparam int AW = 10;
  localparam int ND = 896;

  logic          clk = 1'b0;
  logic          rst, start, ready;
  logic          ce, we, valid, last, busy, done;
  logic [AW-1:0] addr;
  logic [DW-1:0] q, data;

  logic          s_start, s_ready;
  logic          s_ce, s_we, s_valid, s_last, s_busy, s_done;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_q, s_data;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  ofmap_drain #(.MEM2_DATA_WIDTH(DW), .MEM2_ADDR_WIDTH(AW), .MEM2_DEPTH(ND), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start_i(start),
    .mem2_ce1(ce), .mem2_we1(we), .mem2_addr1(addr), .mem2_q1(q),
    .m_valid_o(valid), .m_ready_i(ready), .m_data_o(data), .m_last_o(last),
    .busy_o(busy), .done_o(done));

  ofmap_drain #(.MEM2_DATA_WIDTH(DW), .MEM2_ADDR_WIDTH(AW), .MEM2_DEPTH(1), .FIFO_DEPTH(3)) dut1 (
    .clk(clk), .rst(rst), .start_i(s_start),
    .mem2_ce1(s_ce), .mem2_we1(s_we), .mem2_addr1(s_addr), .mem2_q1(s_q),
    .m_valid_o(s_valid), .m_ready_i(s_ready), .m_data_o(s_data), .m_last_o(s_last),
    .busy_o(s_busy), .done_o(s_done));

  function automatic logic [DW-1:0] exp_word(input int i);
    logic [7:0] b;
    b = i[7:0];
    return {14{b}};
  endfunction

  // BRAM models with the preload pattern, 1-cycle read latency
  always @(posedge clk) begin
    if (ce)   q   <= exp_word(int'(addr));
    if (s_ce) s_q <= exp_word(int'(s_addr));
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " ce"}, 128'(ce), 128'(0));
    chk({tag, " we"}, 128'(we), 128'(0));
    chk({tag, " addr"}, 128'(addr), 128'(0));
    chk({tag, " valid"}, 128'(valid), 128'(0));
    chk({tag, " data"}, 128'(data), 128'(0));
    chk({tag, " last"}, 128'(last), 128'(0));
    chk({tag, " busy"}, 128'(busy), 128'(0));
    chk({tag, " done"}, 128'(done), 128'(0));
  endtask

  localparam int M_READY = 0, M_STALL = 1, M_RAND = 2;

  typedef struct {
    string name;
    int    mode;
    int    restart_beat;
    int    rst_beat;
    int    exp_beats;
    int    exp_dones;
  } case_t;

  case_t cases [6];

  initial begin
    cases[0] = '{"full_rate",  M_READY, -1,  -1, ND,  1};
    cases[1] = '{"stall20",    M_STALL, -1,  -1, ND,  1};
    cases[2] = '{"random30",   M_RAND,  -1,  -1, ND,  1};
    cases[3] = '{"restart",    M_READY, 100, -1, ND,  1};
    cases[4] = '{"reset_mid",  M_READY, -1, 300, 300, 0};
    cases[5] = '{"after_rst",  M_READY, -1,  -1, ND,  1};

    rst = 1'b1; start = 1'b0; ready = 1'b0; s_start = 1'b0; s_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 6; k++) begin
      int  c, beats, dones, issued, max_out;
      int  first_valid_c, first_hs_c, last_hs_c, done_c;
      bit  stop, bad_data, bad_last;
      c = 0; beats = 0; dones = 0; issued = 0; max_out = 0;
      first_valid_c = -1; first_hs_c = -1; last_hs_c = -1; done_c = -1;
      stop = 1'b0; bad_data = 1'b0; bad_last = 1'b0;

      start = 1'b1;
      @(posedge clk); #1;
      while (!stop && c < 20000) begin
        start = 1'b0;
        if (valid && first_valid_c < 0) first_valid_c = c;
        if (done) begin dones++; if (done_c < 0) done_c = c; end
        if (ce) issued++;
        if (issued - beats > max_out) max_out = issued - beats;

        if (cases[k].mode == M_STALL && c == 19) begin
          chk("stall issued", 128'(issued), 128'(4));
          chk("stall ce off", 128'(ce), 128'(0));
          chk("stall valid", 128'(valid), 128'(1));
          chk("stall head", 128'(data), 128'(exp_word(0)));
        end

        if (cases[k].rst_beat >= 0 && beats == cases[k].rst_beat) begin
          rst = 1'b1; ready = 1'b0;
          @(posedge clk); #1;
          check_idle("mid-run reset");
          rst = 1'b0;
          stop = 1'b1;
        end else begin
          case (cases[k].mode)
            M_STALL: ready = (c >= 20);
            M_RAND:  ready = ($urandom_range(0, 99) < 30);
            default: ready = 1'b1;
          endcase
          if (valid && ready) begin
            if (data !== exp_word(beats)) begin
              if (!bad_data) chk({cases[k].name, " data"}, 128'(data), 128'(exp_word(beats)));
              bad_data = 1'b1;
            end
            if (last !== (beats == ND - 1)) begin
              if (!bad_last) chk({cases[k].name, " last"}, 128'(last), 128'(beats == ND - 1));
              bad_last = 1'b1;
            end
            if (first_hs_c < 0) first_hs_c = c;
            last_hs_c = c;
            beats++;
            if (beats == cases[k].restart_beat) start = 1'b1;
          end
          if (done_c >= 0 && c > done_c + 3) stop = 1'b1;
          @(posedge clk); #1;
          c++;
        end
      end
      ready = 1'b0;

      chk({cases[k].name, " data stream ok"}, 128'(bad_data), 128'(0));
      chk({cases[k].name, " last flags ok"}, 128'(bad_last), 128'(0));
      chk({cases[k].name, " beats"}, 128'(beats), 128'(cases[k].exp_beats));
      chk({cases[k].name, " done pulses"}, 128'(dones), 128'(cases[k].exp_dones));
      chk({cases[k].name, " first valid cycle"}, 128'(first_valid_c), 128'(2));
      chk({cases[k].name, " no overflow"}, 128'(max_out <= 4), 128'(1));
      if (cases[k].exp_dones > 0) begin
        chk({cases[k].name, " done after last"}, 128'(done_c), 128'(last_hs_c + 1));
        chk({cases[k].name, " idle busy"}, 128'(busy), 128'(0));
      end
      if (cases[k].mode == M_READY && cases[k].rst_beat < 0)
        chk({cases[k].name, " no bubbles"}, 128'(last_hs_c - first_hs_c + 1), 128'(beats));
      repeat (2) @(posedge clk);
      #1;
    end

    // Single-word build: one beat tagged last, then done and back to idle
    begin
      int beats, dones, first_valid_c, last_seen;
      beats = 0; dones = 0; first_valid_c = -1; last_seen = 0;
      s_ready = 1'b1;
      s_start = 1'b1;
      @(posedge clk); #1;
      s_start = 1'b0;
      chk("d1 ce at start", 128'(s_ce), 128'(1));
      chk("d1 addr at start", 128'(s_addr), 128'(0));
      for (int c = 0; c < 20; c++) begin
        if (c > 0) begin @(posedge clk); #1; end
        if (s_valid && first_valid_c < 0) first_valid_c = c;
        if (s_done) dones++;
        if (s_valid) begin
          beats++;
          last_seen = int'(s_last);
          chk("d1 data", 128'(s_data), 128'(exp_word(0)));
        end
      end
      chk("d1 beats", 128'(beats), 128'(1));
      chk("d1 last", 128'(last_seen), 128'(1));
      chk("d1 first valid", 128'(first_valid_c), 128'(2));
      chk("d1 done pulses", 128'(dones), 128'(1));
      chk("d1 idle busy", 128'(s_busy), 128'(0));
      chk("d1 idle ce", 128'(s_ce), 128'(0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
